rca64_standard: RTL and testbench
=================================

// Module: rca64_standard
// PURPOSE
//  - 64-bit ripple-carry adder built from a chain of single-bit full adders.
//  - Computes {C_Out,S} = A + B + C0 and registers the result on the clock.
//  - Serves as the baseline adder datapath that other adder variants are
//    benchmarked against.
// PARAMETERS
//  - WIDTH  64  operand/sum width in bits; the carry chain length equals WIDTH
// PORTS
//  - clk    in   1      single clock; all state updates on rising edge
//  - rst    in   1      reset, asynchronous, active-high
//  - A      in   WIDTH  operand A, unsigned
//  - B      in   WIDTH  operand B, unsigned
//  - C0     in   1      carry-in into bit 0
//  - S      out  WIDTH  registered sum, bits [WIDTH-1:0] of A+B+C0
//  - C_Out  out  1      registered carry-out of bit WIDTH-1
// BEHAVIOUR
//  - Reset: one clock, clk; reset rst is asynchronous and active-high.
//    While rst=1: S=0, C_Out=0 immediately, with no wait for a clock edge.
//    The first capture after deassertion happens on the next rising clk.
//  - Datapath: c[0]=C0; for i in 0..WIDTH-1:
//    s[i]   = A[i]^B[i]^c[i]
//    c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i])
//    The carry chain is strictly rippled: no lookahead, no select logic.
//  - Registering: on each rising clk with rst=0, S<=s[WIDTH-1:0] and
//    C_Out<=c[WIDTH].
//  - Latency: exactly 1 cycle from stable A/B/C0 to S/C_Out.
//    Throughput: 1 result per cycle. There is no handshake; inputs are sampled
//    on every edge.
//  - Arithmetic is unsigned modulo 2^WIDTH, with the overflow carry on C_Out.
//    There is no signed-overflow output.
//  - Boundaries:
//    - all-ones + 1 wraps to S=0 with C_Out=1.
//    - 0+0+0 gives S=0, C_Out=0.
//    - C0=1 with A+B = 2^WIDTH-1 propagates through all WIDTH stages
//      (worst-case path).
//  - Input changes between edges have no effect on the outputs until the next
//    edge.
//  - Reset asserted mid-stream clears the outputs at once. The in-flight result
//    is discarded.
//  - Timing: the combinational ripple path from A/B/C0 to the output registers
//    must close within one clk period. The ripple path is the critical path and
//    must not be restructured.
// STRUCTURE
//  - Sub-module full_adder (a, b, cin -> s, cout), instantiated WIDTH times with
//    a generate loop. The carry wires are chained c[i] -> c[i+1].
//  - Top level holds only the generate chain plus the S/C_Out output registers.
//  - Shared package: ADDER_WIDTH=64 constant.
//  - No typedefs are needed.
// TESTING
//  - Golden model: behavioural {C_Out,S} = A + B + C0, compared 1 cycle after
//    each input change. The bench flags any mismatch of S or C_Out.
//  - Directed scenarios:
//    - Reset/zero: rst=1 -> S=0, C_Out=0 asynchronously. Then A=0, B=0, C0=0
//      -> S=0, C_Out=0.
//    - Full propagate: A=64'h1, B=64'hFFFF_FFFF_FFFF_FFFF, C0=0 -> S=0, C_Out=1.
//      With C0=1 -> S=64'h1, C_Out=1.
//    - Mixed: A=64'hFFFF_FFFF_FFFF_FFFF, B=64'hAAAA_AAAA_AAAA_AAAA, C0=0
//      -> S=64'hAAAA_AAAA_AAAA_AAA9, C_Out=1.
//      With C0=1 -> S=64'hAAAA_AAAA_AAAA_AAAA, C_Out=1.
//    - Low-byte carry: A=64'hFF, B=64'hFF01, C0=0 -> S=64'h1_0000, C_Out=0.
//      With C0=1 -> S=64'h1_0001, C_Out=0.
//    - Reset mid-operation: hold A=B=all-ones with outputs valid, then assert
//      rst between edges -> S=0 and C_Out=0 before the next edge. After release,
//      the next edge gives S=64'hFFFF_FFFF_FFFF_FFFE, C_Out=1.
//    - Carry-in toggle: pulse C0 for a single cycle -> the outputs follow with
//      exactly 1-cycle latency, and there is no change between edges.

Source files
------------

// File: rtl/rca64_standard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rca64_standard_pkg
//  Description : Shared constants for the baseline ripple-carry adder slice.
//                ADDER_WIDTH sets the operand/sum width and therefore the
//                length of the carry chain.
//  Revision    : 1.0 - initial release
// ============================================================================
package rca64_standard_pkg;

  localparam int ADDER_WIDTH = 64;

endpackage : rca64_standard_pkg
`default_nettype wire

// File: rtl/rca64_standard_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : rca64_standard_full_adder
//  Description : Single-bit full adder, one stage of the ripple carry chain.
//  Ports       : a, b   - operand bits
//                cin    - carry from the previous (less significant) stage
//                s      - sum bit
//                cout   - carry into the next (more significant) stage
//  Revision    : 1.0 - initial release
// ============================================================================
module rca64_standard_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_prop;

  // Propagate term is shared between the sum and the carry expressions.
  assign w_prop = a ^ b;
  assign s      = w_prop ^ cin;
  assign cout   = (a & b) | (cin & w_prop);

endmodule : rca64_standard_full_adder
`default_nettype wire

// File: rtl/rca64_standard.sv
`default_nettype none
// ============================================================================
//  Module      : rca64_standard
//  Description : WIDTH-bit ripple-carry adder with registered outputs.
//                {C_Out,S} = A + B + C0, captured on every rising clk edge.
//                Baseline datapath for comparing other adder variants; the
//                carry is strictly rippled through WIDTH full-adder stages.
//  Ports       : clk   - clock, rising edge
//                rst   - asynchronous active-high reset, clears S and C_Out
//                A, B  - unsigned operands [WIDTH-1:0]
//                C0    - carry into bit 0
//                S     - registered sum [WIDTH-1:0]
//                C_Out - registered carry out of bit WIDTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module rca64_standard
  import rca64_standard_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic [WIDTH-1:0] S,
  output logic             C_Out
);

  // Carry chain: w_carry[i] feeds stage i, w_carry[WIDTH] is the final carry.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;

  assign w_carry[0] = C0;

  // Stages are chained strictly in order; this ripple path is intentionally
  // left unoptimised as the reference critical path.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa_chain
    rca64_standard_full_adder u_fa (
      .a    (A[gi]),
      .b    (B[gi]),
      .cin  (w_carry[gi]),
      .s    (w_sum[gi]),
      .cout (w_carry[gi+1])
    );
  end

  assign sum_d  = w_sum;
  assign cout_d = w_carry[WIDTH];

  // Asynchronous clear: outputs drop to zero as soon as rst rises, and any
  // result in flight is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign S     = sum_q;
  assign C_Out = cout_q;

endmodule : rca64_standard
`default_nettype wire

// File: tb/tb_rca64_standard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca64_standard
//  Description : Self-checking bench for rca64_standard. Expected results come
//                from plain 65-bit arithmetic on A + B + C0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rca64_standard;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C0;
  logic [W-1:0] S;
  logic         C_Out;

  int total;
  int bad;

  rca64_standard #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .C0    (C0),
    .S     (S),
    .C_Out (C_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] es, input logic ec);
    total++;
    assert (S === es) else begin
      bad++;
      $error("FAIL %s S got=%h exp=%h", tag, S, es);
    end
    total++;
    assert (C_Out === ec) else begin
      bad++;
      $error("FAIL %s C_Out got=%b exp=%b", tag, C_Out, ec);
    end
  endtask

  // Drive operands, let one rising edge capture them, check 1 ns later
  // against the reference sum.
  task automatic step(input string tag, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic c);
    logic [W:0] r;
    A  = a;
    B  = b;
    C0 = c;
    r  = ref_add(a, b, c);
    @(posedge clk);
    #1;
    chk(tag, r[W-1:0], r[W]);
  endtask

  initial begin
    logic [W:0]   r;
    logic [W:0]   r_prev;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    A     = '0;
    B     = '0;
    C0    = 1'b0;

    // Reset is visible before any clock edge has occurred.
    #1;
    chk("reset_async", '0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Directed cases with hand-derived expectations.
    step("zero", '0, '0, 1'b0);
    chk("zero_const", 64'h0, 1'b0);
    step("full_prop", 64'h1, ONES, 1'b0);
    chk("full_prop_const", 64'h0, 1'b1);
    step("full_prop_c0", 64'h1, ONES, 1'b1);
    chk("full_prop_c0_const", 64'h1, 1'b1);
    step("worst_path", 64'h0, ONES, 1'b1);
    chk("worst_path_const", 64'h0, 1'b1);
    step("mixed", ONES, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    chk("mixed_const", 64'hAAAA_AAAA_AAAA_AAA9, 1'b1);
    step("mixed_c0", ONES, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    chk("mixed_c0_const", 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    step("lowbyte", 64'hFF, 64'hFF01, 1'b0);
    chk("lowbyte_const", 64'h1_0000, 1'b0);
    step("lowbyte_c0", 64'hFF, 64'hFF01, 1'b1);
    chk("lowbyte_c0_const", 64'h1_0001, 1'b0);

    // Mid-stream reset: outputs valid, then rst asserted between edges.
    step("pre_reset", ONES, ONES, 1'b0);
    chk("pre_reset_const", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_mid_async", '0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_held", '0, 1'b0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);

    // Carry-in pulse: one cycle high, outputs follow with one cycle latency
    // and stay put while inputs change between edges.
    A  = 64'h1234_5678_9ABC_DEF0;
    B  = 64'h0FED_CBA9_8765_4321;
    C0 = 1'b0;
    @(posedge clk);
    #1;
    r_prev = ref_add(A, B, 1'b0);
    chk("pulse_base", r_prev[W-1:0], r_prev[W]);
    C0 = 1'b1;
    #3;
    chk("pulse_between_edges", r_prev[W-1:0], r_prev[W]);
    @(posedge clk);
    #1;
    r = ref_add(A, B, 1'b1);
    chk("pulse_high", r[W-1:0], r[W]);
    C0 = 1'b0;
    A  = ONES;
    #3;
    chk("pulse_hold", r[W-1:0], r[W]);
    @(posedge clk);
    #1;
    r = ref_add(ONES, 64'h0FED_CBA9_8765_4321, 1'b0);
    chk("pulse_low", r[W-1:0], r[W]);

    // Randomised vectors; every fourth one forces B = ~A so the carry has
    // to ripple through long propagate runs.
    for (int i = 0; i < 200; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      if ((i % 4) == 0) rb = ~ra;
      step("random", ra, rb, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rca64_standard
`default_nettype wire
